// File: rtl/exception_seq_pkg.sv
// Shared encodings for the multicycle-CPU exception sequencer.
//   - MemAddrCtrl codes, i.e. the address-mux selects driven onto mem_addr_ctrl
//   - exception cause encodings, as reported on exc_cause
//   - sequencer state encodings
//   - vector_code(): maps a cause to the MemAddrCtrl code of its vector byte
package exception_seq_pkg;

  // MemAddrCtrl address-mux selects
  localparam logic [2:0] MAC_REGA   = 3'd0;
  localparam logic [2:0] MAC_REGB   = 3'd1;
  localparam logic [2:0] MAC_PC     = 3'd2;
  localparam logic [2:0] MAC_V253   = 3'd3;
  localparam logic [2:0] MAC_V254   = 3'd4;
  localparam logic [2:0] MAC_V255   = 3'd5;
  localparam logic [2:0] MAC_ALUOUT = 3'd6;

  // Exception causes
  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_DIV0   = 2'd3;

  // Sequencer states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SAVE = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_LOAD = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Vector byte address select for a given cause. CAUSE_NONE never reaches
  // SAVE, so it simply falls back to the PC select.
  function automatic logic [2:0] vector_code(input logic [1:0] cause);
    logic [2:0] code;
    case (cause)
      CAUSE_OPCODE: code = MAC_V253;
      CAUSE_OVF:    code = MAC_V254;
      CAUSE_DIV0:   code = MAC_V255;
      default:      code = MAC_PC;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/exception_seq.sv
// exception_seq: multicycle-CPU exception sequencer.
//
// On an invalid-opcode, overflow or divide-by-zero request it takes over the
// memory-address mux, writes EPC = PC - 4, steers the address to the
// cause's vector byte (253/254/255), waits MEM_WAIT cycles for memory and
// then loads PC with the zero-extended vector byte.
//
// Sequence: IDLE -> SAVE -> WAIT (MEM_WAIT cycles) -> LOAD -> DONE -> IDLE.
//
// Parameters:
//   MEM_WAIT       memory read latency in cycles (legal range 1..15)
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   exc_opcode     invalid-opcode request (level, sampled only in IDLE)
//   exc_overflow   ALU overflow request
//   exc_div0       divide-by-zero request
//   pc_in          current PC (already PC+4 of the faulting instruction)
//   mem_rdata      memory read data
//   exc_busy       sequencer owns the address mux and the PC/EPC writes
//   mem_addr_ctrl  MemAddrCtrl select; meaningful only while exc_busy
//   epc_write      one-cycle EPC write strobe (SAVE)
//   epc_wdata      pc_in - 4, captured when the request is accepted
//   pc_write       one-cycle PC write strobe (LOAD)
//   pc_wdata       {24'b0, mem_rdata[7:0]}
//   exc_done       one-cycle completion pulse (DONE)
//   exc_cause      last accepted cause (sticky): 0 none, 1 opcode,
//                  2 overflow, 3 div0
module exception_seq
  import exception_seq_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_rdata,
  output logic        exc_busy,
  output logic [2:0]  mem_addr_ctrl,
  output logic        epc_write,
  output logic [31:0] epc_wdata,
  output logic        pc_write,
  output logic [31:0] pc_wdata,
  output logic        exc_done,
  output logic [1:0]  exc_cause
);

  // SAVE loads MEM_WAIT-1, so WAIT spans exactly MEM_WAIT cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_WAIT - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  // Output flops, each computed from the next state, so every output is a
  // plain register with no path from the request inputs.
  logic        busy_q, busy_d;
  logic [2:0]  addr_q, addr_d;
  logic        epc_write_q, epc_write_d;
  logic        pc_write_q, pc_write_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    epc_d   = epc_q;

    case (state_q)
      ST_IDLE: begin
        if (exc_opcode || exc_overflow || exc_div0) begin
          if (exc_opcode)        cause_d = CAUSE_OPCODE;
          else if (exc_overflow) cause_d = CAUSE_OVF;
          else                   cause_d = CAUSE_DIV0;
          epc_d   = pc_in - 32'd4;
          state_d = ST_SAVE;
        end
      end
      ST_SAVE: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_LOAD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_LOAD: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    epc_write_d = (state_d == ST_SAVE);
    pc_write_d  = (state_d == ST_LOAD);
    done_d      = (state_d == ST_DONE);
    // The vector select is held from SAVE through LOAD; otherwise the mux
    // is left on PC.
    if (state_d == ST_SAVE || state_d == ST_WAIT || state_d == ST_LOAD)
      addr_d = vector_code(cause_d);
    else
      addr_d = MAC_PC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cause_q     <= CAUSE_NONE;
      epc_q       <= 32'd0;
      busy_q      <= 1'b0;
      addr_q      <= MAC_PC;
      epc_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      epc_write_q <= epc_write_d;
      pc_write_q  <= pc_write_d;
      done_q      <= done_d;
    end
  end

  assign exc_busy      = busy_q;
  assign mem_addr_ctrl = addr_q;
  assign epc_write     = epc_write_q;
  assign epc_wdata     = epc_q;
  assign pc_write      = pc_write_q;
  assign pc_wdata      = {24'b0, mem_rdata[7:0]};
  assign exc_done      = done_q;
  assign exc_cause     = cause_q;

endmodule

// File: tb/tb_exception_seq.sv
// Testbench for exception_seq. Two instances share the same stimulus:
// index 0 has MEM_WAIT=2 and index 1 has MEM_WAIT=1. Each sequence the
// stimulus starts pushes its expected strobe events (EPC write, PC write,
// done) into a per-instance queue. A monitor samples on the falling edge,
// pops an event whenever a strobe fires, and checks it.
module tb_exception_seq;

  localparam int MW0 = 2;
  localparam int MW1 = 1;

  localparam int EV_EPC  = 0;
  localparam int EV_PC   = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
    logic [2:0]  addr;
    logic [1:0]  cause;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_opcode = 1'b0, exc_overflow = 1'b0, exc_div0 = 1'b0;
  logic [31:0] pc_in = 32'd0, mem_rdata = 32'd0;

  logic        exc_busy  [2];
  logic [2:0]  mem_addr_ctrl [2];
  logic        epc_write [2];
  logic [31:0] epc_wdata [2];
  logic        pc_write  [2];
  logic [31:0] pc_wdata  [2];
  logic        exc_done  [2];
  logic [1:0]  exc_cause [2];

  ev_t q0[$];
  ev_t q1[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  exception_seq #(.MEM_WAIT(MW0)) dut0 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_rdata(mem_rdata),
    .exc_busy(exc_busy[0]), .mem_addr_ctrl(mem_addr_ctrl[0]),
    .epc_write(epc_write[0]), .epc_wdata(epc_wdata[0]),
    .pc_write(pc_write[0]), .pc_wdata(pc_wdata[0]),
    .exc_done(exc_done[0]), .exc_cause(exc_cause[0])
  );

  exception_seq #(.MEM_WAIT(MW1)) dut1 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_rdata(mem_rdata),
    .exc_busy(exc_busy[1]), .mem_addr_ctrl(mem_addr_ctrl[1]),
    .epc_write(epc_write[1]), .epc_wdata(epc_wdata[1]),
    .pc_write(pc_write[1]), .pc_wdata(pc_wdata[1]),
    .exc_done(exc_done[1]), .exc_cause(exc_cause[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cyc %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push(input int d, input int kind, input int c,
                               input logic [31:0] data, input logic [2:0] addr,
                               input logic [1:0] cause);
    ev_t e;
    e.kind = kind; e.cyc = c; e.data = data; e.addr = addr; e.cause = cause;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Expected events for a full sequence accepted at posedge number e.
  // Observed in the cycle after edge e: SAVE; after edge e+1+MW: LOAD;
  // after edge e+2+MW: DONE.
  function automatic void push_seq(input int e, input logic [31:0] epc,
                                   input logic [31:0] pcw, input logic [2:0] addr,
                                   input logic [1:0] cause, input bit full);
    for (int d = 0; d < 2; d++) begin
      int mw;
      mw = (d == 0) ? MW0 : MW1;
      push(d, EV_EPC, e, epc, addr, cause);
      if (full) begin
        push(d, EV_PC,   e + 1 + mw, pcw, addr, cause);
        push(d, EV_DONE, e + 2 + mw, 32'd0, 3'd2, cause);
      end
    end
  endfunction

  function automatic void observe(input int d, input int kind, input logic [31:0] data);
    ev_t   e;
    string tag;
    tag = $sformatf("dut%0d.%s", d, kind == EV_EPC ? "epc_write" :
                                   kind == EV_PC ? "pc_write" : "exc_done");
    n_checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      $display("FAIL %s unexpected: got strobe at cyc %0d, expected none", tag, cyc);
      return;
    end
    n_pass++;
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk({tag, ".kind"}, kind, e.kind);
    chk({tag, ".cycle"}, cyc, e.cyc);
    chk({tag, ".busy"}, {31'd0, exc_busy[d]}, 32'd1);
    chk({tag, ".cause"}, {30'd0, exc_cause[d]}, {30'd0, e.cause});
    if (kind != EV_DONE) begin
      chk({tag, ".data"}, data, e.data);
      chk({tag, ".addr"}, {29'd0, mem_addr_ctrl[d]}, {29'd0, e.addr});
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (epc_write[d]) observe(d, EV_EPC, epc_wdata[d]);
      if (pc_write[d])  observe(d, EV_PC, pc_wdata[d]);
      if (exc_done[d])  observe(d, EV_DONE, 32'd0);
      if (epc_write[d] || pc_write[d] || exc_done[d])
        $display("dut%0d cyc %0d: epc_w=%0b pc_w=%0b done=%0b addr=%0d epc=0x%08h pcw=0x%08h cause=%0d",
                 d, cyc, epc_write[d], pc_write[d], exc_done[d], mem_addr_ctrl[d],
                 epc_wdata[d], pc_wdata[d], exc_cause[d]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input logic [1:0] cause,
                            input logic [31:0] epc);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.dut%0d.busy", name, d), {31'd0, exc_busy[d]}, 32'd0);
      chk($sformatf("%s.dut%0d.addr", name, d), {29'd0, mem_addr_ctrl[d]}, 32'd2);
      chk($sformatf("%s.dut%0d.strobes", name, d),
          {29'd0, epc_write[d], pc_write[d], exc_done[d]}, 32'd0);
      chk($sformatf("%s.dut%0d.cause", name, d), {30'd0, exc_cause[d]}, {30'd0, cause});
      chk($sformatf("%s.dut%0d.epc", name, d), epc_wdata[d], epc);
    end
  endtask

  // Raise a request set, let one edge accept it, drop it; returns accept edge.
  task automatic fire(input logic op, input logic ov, input logic dz,
                      input logic [31:0] pc, input logic [31:0] rd, output int e);
    pc_in = pc; mem_rdata = rd;
    exc_opcode = op; exc_overflow = ov; exc_div0 = dz;
    @(posedge clk);
    e = cyc + 1;   // cyc updates with a nonblocking write on this edge
    #1;
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
  endtask

  initial begin
    int e;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    $display("reset/idle check");
    check_idle("reset", 2'd0, 32'd0);

    // Overflow: EPC 0x100, vector 254, PC <- 0x3C.
    push_seq(cyc + 1, 32'h0000_0100, 32'h0000_003C, 3'd4, 2'd2, 1'b1);
    fire(1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'hFFFF_FF3C, e);
    $display("overflow accepted at edge %0d", e);
    repeat (8) step();
    check_idle("after_ovf", 2'd2, 32'h0000_0100);

    // All three at once: opcode wins.
    push_seq(cyc + 1, 32'h0000_1FFC, 32'h0000_0078, 3'd3, 2'd1, 1'b1);
    fire(1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, e);
    $display("all-three accepted at edge %0d", e);
    repeat (8) step();

    // Opcode, with div0 pulsed during WAIT: must be ignored.
    push_seq(cyc + 1, 32'h0000_003C, 32'h0000_00AA, 3'd3, 2'd1, 1'b1);
    fire(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_00AA, e);
    step();                       // both instances now in WAIT
    exc_div0 = 1'b1;
    step();
    exc_div0 = 1'b0;
    $display("opcode accepted at edge %0d, div0 pulsed in WAIT", e);
    repeat (8) step();
    check_idle("after_ignored_div0", 2'd1, 32'h0000_003C);

    // Div0 alone: vector 255, upper bits of mem_rdata dropped.
    push_seq(cyc + 1, 32'h0000_000C, 32'h0000_00FF, 3'd5, 2'd3, 1'b1);
    fire(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_01FF, e);
    $display("div0 accepted at edge %0d", e);
    repeat (8) step();

    // Reset in WAIT: only the EPC write happens, no PC write, no done.
    push_seq(cyc + 1, 32'h0000_0FFC, 32'd0, 3'd4, 2'd2, 1'b0);
    fire(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_0055, e);
    step();                       // both in WAIT now
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("reset asserted in WAIT after accept edge %0d", e);
    check_idle("reset_in_wait", 2'd0, 32'd0);
    repeat (6) step();
    check_idle("after_reset_in_wait", 2'd0, 32'd0);

    // PC wrap: 0 - 4 = 0xFFFF_FFFC.
    push_seq(cyc + 1, 32'hFFFF_FFFC, 32'h0000_0001, 3'd5, 2'd3, 1'b1);
    fire(1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hABCD_EF01, e);
    $display("pc wrap accepted at edge %0d", e);
    repeat (8) step();
    check_idle("after_wrap", 2'd3, 32'hFFFF_FFFC);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
